// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command-driven controller for a bidirectional shift register
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CW-1:0]    cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_in,
  output logic             sr_mode,
  output logic             sr_en,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_idx;
  logic [WIDTH-1:0] r_data;
  logic             r_sr_in;
  logic             r_sr_mode;
  logic [WIDTH-1:0] r_rsp_data;

  logic [CW-1:0]    w_eff_count;
  logic             w_last;
  logic             w_accept;

  // Requested counts above the register width would only rotate data back out, so clamp them.
  assign w_eff_count = (cmd_count > CW'(WIDTH)) ? CW'(WIDTH) : cmd_count;
  assign w_last      = (r_idx == r_count - CW'(1));
  assign w_accept    = (r_state == IDLE) && cmd_valid;

  assign sr_in    = r_sr_in;
  assign sr_mode  = r_sr_mode;
  assign rsp_data = r_rsp_data;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    sr_en       = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_state_nxt = (w_eff_count != '0) ? SHIFT : CAPTURE;
        end
      end
      SHIFT: begin
        sr_en = 1'b1;
        if (w_last) begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: r_data holds the not-yet-presented serial bits, so sr_in for the
  // next shift is always r_data[0]; sr_in/sr_mode only move when a shift follows.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_sr_in    <= 1'b0;
      r_sr_mode  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_count <= w_eff_count;
        r_idx   <= '0;
        r_data  <= cmd_data >> 1;
        if (w_eff_count != '0) begin
          r_sr_in   <= cmd_data[0];
          r_sr_mode <= cmd_dir;
        end
      end
      if (r_state == SHIFT) begin
        r_idx <= r_idx + CW'(1);
        if (!w_last) begin
          r_sr_in <= r_data[0];
          r_data  <= r_data >> 1;
        end
      end
      if (r_state == CAPTURE) begin
        r_rsp_data <= sr_q;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [2:0] cmd_count = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       sr_in;
  logic       sr_mode;
  logic       sr_en;
  logic [3:0] sr_q;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       busy;

  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] reg_q = 4'd0;

  int n_checks = 0;
  int n_errors = 0;

  shift_sequencer #(.WIDTH(4), .CW(3)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .sr_in     (sr_in),
    .sr_mode   (sr_mode),
    .sr_en     (sr_en),
    .sr_q      (sr_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bench model of the external bidirectional shift register, with a preload port.
  always @(posedge clk) begin
    if (load_en) reg_q <= load_val;
    else if (sr_en) reg_q <= sr_mode ? {reg_q[2:0], sr_in} : {sr_in, reg_q[3:1]};
  end
  assign sr_q = reg_q;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] v);
    @(negedge clk);
    load_en = 1'b1;
    load_val = v;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic issue(input logic d, input logic [2:0] c, input logic [3:0] data);
    @(negedge clk);
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_dir = d;
    cmd_count = c;
    cmd_data = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Called right after the accept edge; returns at the negedge of the first DONE cycle.
  task automatic wait_rsp(input logic d, input logic [3:0] data, input int n, input logic [3:0] exp);
    int en_cnt = 0;
    int cyc = 0;
    bit seen = 0;
    logic [3:0] dv = data;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (sr_en) begin
        if (en_cnt < 4) check_eq("sr_in_bit", 32'(sr_in), 32'(dv[en_cnt]));
        check_eq("sr_mode", 32'(sr_mode), 32'(d));
        en_cnt++;
      end
      if (rsp_valid) begin
        seen = 1;
        cyc = k;
      end
    end
    check_eq("shift_cycles", 32'(en_cnt), 32'(n));
    check_eq("rsp_valid_cycle", 32'(cyc), 32'(n + 2));
    check_eq("rsp_data", 32'(rsp_data), 32'(exp));
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen_en;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_sr_en", 32'(sr_en), 32'd0);
    check_eq("rst_sr_in", 32'(sr_in), 32'd0);
    check_eq("rst_sr_mode", 32'(sr_mode), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    clr = 1'b1;

    // Left shift 1011 from 0000 -> 1101
    preload(4'b0000);
    issue(1'b1, 3'd4, 4'b1011);
    wait_rsp(1'b1, 4'b1011, 4, 4'b1101);
    finish_rsp();

    // Right shift 1011 from 0000 -> 1011
    preload(4'b0000);
    issue(1'b0, 3'd4, 4'b1011);
    wait_rsp(1'b0, 4'b1011, 4, 4'b1011);
    finish_rsp();

    // Partial right shift, 2 bits of 0011 -> 1100
    preload(4'b0000);
    issue(1'b0, 3'd2, 4'b0011);
    wait_rsp(1'b0, 4'b0011, 2, 4'b1100);
    finish_rsp();

    // Clamped count 7 -> 4 left shifts of 1011 -> 1101
    preload(4'b0000);
    issue(1'b1, 3'd7, 4'b1011);
    wait_rsp(1'b1, 4'b1011, 4, 4'b1101);
    finish_rsp();

    // Zero count: read-only, returns preloaded 0110
    preload(4'b0110);
    issue(1'b1, 3'd0, 4'b1111);
    wait_rsp(1'b1, 4'b1111, 0, 4'b0110);
    finish_rsp();

    // Backpressure in DONE with a pending command
    preload(4'b0000);
    issue(1'b1, 3'd4, 4'b1011);
    wait_rsp(1'b1, 4'b1011, 4, 4'b1101);
    cmd_valid = 1'b1;
    cmd_dir = 1'b0;
    cmd_count = 3'd2;
    cmd_data = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      load_en = (i == 0);
      load_val = 4'b0000;
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_data", 32'(rsp_data), 32'hD);
      check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    load_en = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_idle_ready", 32'(cmd_ready), 32'd1);
    check_eq("bp_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp(1'b0, 4'b0011, 2, 4'b1100);
    finish_rsp();

    // Reset asserted after two shifts of a four-shift command
    preload(4'b0000);
    issue(1'b1, 3'd4, 4'b1111);
    seen_en = 0;
    for (int k = 0; k < 10 && seen_en < 2; k++) begin
      @(negedge clk);
      if (sr_en) seen_en++;
    end
    check_eq("mid_shift_reached", 32'(seen_en), 32'd2);
    clr = 1'b0;
    #1;
    check_eq("abort_sr_en", 32'(sr_en), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("abort_reg_kept", 32'(reg_q), 32'h1);
    clr = 1'b1;

    // Normal completion after reset
    preload(4'b0000);
    issue(1'b1, 3'd4, 4'b1011);
    wait_rsp(1'b1, 4'b1011, 4, 4'b1101);
    finish_rsp();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
